alu32_muldiv_seq: RTL and testbench
===================================

Name: alu32_muldiv_seq

Overview:
- Multi-cycle sequencer for 32-bit unsigned multiply and divide (MULTU/DIVU) in the mips32 datapath.
- Reuses the existing 32-bit ALU: the block drives the ALU operands and opcode, then samples its result and carry-out once per cycle.
- Produces a 64-bit hi/lo result over 32 iterations, using a start/busy/done handshake.
- While the block owns the ALU, the datapath's ALU input mux selects the block's operands through the alu_own output.

Parameters:
- ITER, 32, number of iterations; equals the operand width. Fixed at 32; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle request; sampled only in IDLE or DONE.
- div_sel  input  1  sampled with start: 0 selects multiply, 1 selects divide.
- op_a  input  32  multiplier or dividend; sampled with start.
- op_b  input  32  multiplicand or divisor; sampled with start.
- alu_a  output  32  ALU operand a.
- alu_b  output  32  ALU operand b.
- alu_op  output  3  ALU opcode: 010 is ADD, 110 is SUB; 000 when idle.
- alu_r  input  32  ALU result; combinational from alu_a, alu_b, alu_op.
- alu_carry_out  input  1  ALU carry-out of bit 31; for SUB, 1 means no borrow.
- alu_own  output  1  high in RUN; datapath ALU mux selects this block.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- hi  output  32  product[63:32] or remainder.
- lo  output  32  product[31:0] or quotient.

Behaviour:
- Reset is asynchronous, active-low. It forces state=IDLE, count=0, hi=0, lo=0, the latched operand register (opnd)=0 and mode=0. Outputs go to busy=0, done=0, alu_own=0, alu_op=000, alu_a=0, alu_b=0.
- Reset mid-operation aborts the operation immediately; no result is produced.
- States are IDLE, RUN and DONE.
  - IDLE/DONE to RUN: on an edge with start=1. The block latches opnd=op_b and mode=div_sel, and loads lo=op_a, hi=0, count=0.
  - RUN: performs one iteration per edge and increments count. On the edge where count==31, the final iteration is written and the state moves to DONE.
  - DONE: lasts exactly one cycle; done=1. Moves to IDLE unless start=1, which begins a new operation at that edge.
- start is ignored in RUN: no restart, and operands are not resampled.
- Latency: the start edge is edge 0. Iterations occur on edges 1..32. done is high during the cycle after edge 32.
- hi and lo are valid in DONE and hold their value until the next accepted start or reset.
- Outputs alu_a, alu_b and alu_op are combinational from the registers. Outside RUN they are 0, 0 and 000.
- Multiply iteration (mode=0):
  - ALU drive: alu_a=hi, alu_b=(lo[0] ? opnd : 0), alu_op=010.
  - Update: hi <= {alu_carry_out, alu_r[31:1]}, lo <= {alu_r[0], lo[31:1]}.
  - After 32 iterations, {hi,lo} = op_a*op_b, unsigned and exact over 64 bits.
- Divide iteration (mode=1, restoring):
  - Shifted remainder: rs = {hi[30:0], lo[31]}, with msb = hi[31].
  - ALU drive: alu_a=rs, alu_b=opnd, alu_op=110.
  - ok = msb | alu_carry_out.
  - Update: hi <= ok ? alu_r : rs, lo <= {lo[30:0], ok}.
  - Result: lo is the quotient and hi is the remainder, unsigned.
- Divide by zero is not trapped. The natural result is required: lo=0xFFFFFFFF, hi=op_a.
- Operands are latched at start, so changing op_a or op_b during RUN has no effect.

Test Plan:
- Multiply 7 by 6: start, div_sel=0, op_a=7, op_b=6. Requires done exactly 33 cycles after the start edge, busy high for 32 cycles, hi=0x00000000, lo=0x0000002A.
- Multiply max operands: op_a=op_b=0xFFFFFFFF. Requires hi=0xFFFFFFFE, lo=0x00000001; alu_op=010 on every RUN cycle.
- Divide 100 by 7: div_sel=1, op_a=100, op_b=7. Requires lo=14, hi=2.
- Divide with msb set: op_a=0x80000000, op_b=3. Requires lo=0x2AAAAAAA, hi=2. Also op_a=0xFFFFFFFF, op_b=0x80000001 requires lo=1, hi=0x7FFFFFFE.
- Divide by zero: op_a=0x12345678, op_b=0. Requires lo=0xFFFFFFFF, hi=0x12345678, with no error indication.
- Control boundaries:
  - Pulse start again at count 10 with different operands: it is ignored and the original result is delivered.
  - Drop rst_n at count 15: busy, alu_own, hi and lo are 0 immediately, and no done pulse occurs.
  - Hold start=1 in DONE: a back-to-back operation starts, with done high for one cycle only.

Source files
------------

// File: rtl/alu32_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu32_muldiv_seq
//  Purpose  : Multi-cycle sequencer for 32-bit unsigned multiply (MULTU) and
//             restoring divide (DIVU). It borrows the shared datapath ALU for
//             one add/subtract per cycle and builds a 64-bit hi/lo result
//             over ITER iterations, using a start/busy/done handshake.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             start, div_sel      - request pulse and mul(0)/div(1) select
//             op_a, op_b          - multiplier/dividend, multiplicand/divisor
//             alu_a, alu_b, alu_op- operands and opcode driven to the ALU
//             alu_r, alu_carry_out- ALU result and carry-out of bit 31
//             alu_own             - datapath ALU mux selects this block
//             busy, done          - RUN indication and one-cycle done pulse
//             hi, lo              - product[63:32]/remainder, product[31:0]/quotient
//  Revision : 1.0 - initial release
// ============================================================================
module alu32_muldiv_seq #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        div_sel,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_r,
  input  logic        alu_carry_out,
  output logic        alu_own,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int         CNT_W    = $clog2(ITER);
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      opnd_q, opnd_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Divide step: partial remainder shifted left by one, with the bit that
  // falls out of the top kept separately. If that bit is set the shifted
  // value is at least 2^32 and therefore always exceeds the divisor, even
  // when the 32-bit subtraction reports a borrow.
  logic [31:0] rs;
  logic        rs_msb;
  logic        div_ok;

  assign rs     = {hi_q[30:0], lo_q[31]};
  assign rs_msb = hi_q[31];
  assign div_ok = rs_msb | alu_carry_out;

  // ALU drive is combinational from the registers so the ALU result is
  // available for capture on the same edge.
  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = OP_NONE;
    if (state_q == S_RUN) begin
      if (mode_q) begin
        alu_a  = rs;
        alu_b  = opnd_q;
        alu_op = OP_SUB;
      end else begin
        alu_a  = hi_q;
        alu_b  = lo_q[0] ? opnd_q : 32'd0;
        alu_op = OP_ADD;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    mode_d  = mode_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mode_q) begin
          hi_d = div_ok ? alu_r : rs;
          lo_d = {lo_q[30:0], div_ok};
        end else begin
          // Shift-add: the carry becomes the new top bit of hi, the bit
          // shifted out of the sum moves into the top of lo.
          hi_d = {alu_carry_out, alu_r[31:1]};
          lo_d = {alu_r[0], lo_q[31:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        if (start) begin
          state_d = S_RUN;
          opnd_d  = op_b;
          mode_d  = div_sel;
          lo_d    = op_a;
          hi_d    = 32'd0;
          count_d = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      opnd_q  <= 32'd0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign alu_own = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu32_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu32_muldiv_seq
//  Purpose  : Directed self-checking bench for alu32_muldiv_seq, with a
//             behavioural model of the shared 32-bit ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu32_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        div_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_carry_out;
  logic        alu_own;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  alu32_muldiv_seq #(.ITER(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .div_sel       (div_sel),
    .op_a          (op_a),
    .op_b          (op_b),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_op        (alu_op),
    .alu_r         (alu_r),
    .alu_carry_out (alu_carry_out),
    .alu_own       (alu_own),
    .busy          (busy),
    .done          (done),
    .hi            (hi),
    .lo            (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: ADD and SUB with carry-out (SUB carry = no borrow).
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = 33'd0;
    case (alu_op)
      3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b110:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: alu_sum = 33'd0;
    endcase
  end
  assign alu_r         = alu_sum[31:0];
  assign alu_carry_out = alu_sum[32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and let the start edge pass; operands are scrambled
  // afterwards so any resampling during RUN would corrupt the result.
  task automatic launch(input logic dv, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    div_sel = dv;
    op_a    = a;
    op_b    = b;
    @(posedge clk); #1;
    start   = 1'b0;
    div_sel = ~dv;
    op_a    = $urandom;
    op_b    = $urandom;
  endtask

  // Observe from the cycle beginning at the start edge (cycle 1) until done.
  // Optionally pulses start with other operands when count == glitch_cnt.
  task automatic wait_done(input logic dv, input int glitch_cnt,
                           output int done_cyc, output int busy_cyc,
                           output int bad_op, output int bad_own);
    done_cyc = -1;
    busy_cyc = 0;
    bad_op   = 0;
    bad_own  = 0;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      if (busy) begin
        busy_cyc++;
        if (alu_op !== (dv ? 3'b110 : 3'b010)) bad_op++;
      end
      if (alu_own !== busy) bad_own++;
      if (done) begin
        done_cyc = k;
      end else begin
        start = (glitch_cnt >= 0 && k == glitch_cnt + 1);
        if (start) begin
          div_sel = ~dv;
          op_a    = 32'h0000_0009;
          op_b    = 32'h0000_0003;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  int dcyc, bcyc, bop, bown, ndone;

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    div_sel = 1'b0;
    op_a    = 32'd0;
    op_b    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",    {63'd0, busy},    64'd0);
    check("reset done",    {63'd0, done},    64'd0);
    check("reset alu_own", {63'd0, alu_own}, 64'd0);
    check("reset alu_op",  {61'd0, alu_op},  64'd0);
    check("reset alu_ab",  {alu_a, alu_b},   64'd0);
    check("reset hi_lo",   {hi, lo},         64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Multiply 7 x 6 with latency and busy-length checks
    launch(1'b0, 32'd7, 32'd6);
    wait_done(1'b0, -1, dcyc, bcyc, bop, bown);
    check("mul7x6 done cycle", 64'(dcyc), 64'd33);
    check("mul7x6 busy cycles", 64'(bcyc), 64'd32);
    check("mul7x6 alu_own", 64'(bown), 64'd0);
    check("mul7x6 hi_lo", {hi, lo}, 64'h0000_0000_0000_002A);
    @(posedge clk); #1;
    check("mul7x6 done pulse", {63'd0, done}, 64'd0);
    check("idle alu_op", {61'd0, alu_op}, 64'd0);
    check("hold hi_lo", {hi, lo}, 64'h0000_0000_0000_002A);

    // Multiply max operands
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, -1, dcyc, bcyc, bop, bown);
    check("mulmax done cycle", 64'(dcyc), 64'd33);
    check("mulmax alu_op", 64'(bop), 64'd0);
    check("mulmax hi_lo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk); #1;

    // Divides
    launch(1'b1, 32'd100, 32'd7);
    wait_done(1'b1, -1, dcyc, bcyc, bop, bown);
    check("div100/7 alu_op", 64'(bop), 64'd0);
    check("div100/7 hi_lo", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk); #1;

    launch(1'b1, 32'h8000_0000, 32'd3);
    wait_done(1'b1, -1, dcyc, bcyc, bop, bown);
    check("div80000000/3 hi_lo", {hi, lo}, {32'd2, 32'h2AAA_AAAA});
    @(posedge clk); #1;

    launch(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    wait_done(1'b1, -1, dcyc, bcyc, bop, bown);
    check("divmsb hi_lo", {hi, lo}, {32'h7FFF_FFFE, 32'd1});
    @(posedge clk); #1;

    launch(1'b1, 32'h1234_5678, 32'd0);
    wait_done(1'b1, -1, dcyc, bcyc, bop, bown);
    check("div0 done cycle", 64'(dcyc), 64'd33);
    check("div0 hi_lo", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    @(posedge clk); #1;

    // start pulsed at count 10 is ignored
    launch(1'b0, 32'd1000, 32'd1000);
    wait_done(1'b0, 10, dcyc, bcyc, bop, bown);
    check("restart ignored done cycle", 64'(dcyc), 64'd33);
    check("restart ignored hi_lo", {hi, lo}, 64'd1_000_000);
    @(posedge clk); #1;

    // Back-to-back: start held in DONE
    launch(1'b0, 32'd3, 32'd5);
    wait_done(1'b0, -1, dcyc, bcyc, bop, bown);
    check("b2b first hi_lo", {hi, lo}, 64'd15);
    launch(1'b1, 32'd100, 32'd7);
    check("b2b done single", {63'd0, done}, 64'd0);
    check("b2b busy", {63'd0, busy}, 64'd1);
    wait_done(1'b1, -1, dcyc, bcyc, bop, bown);
    check("b2b second done cycle", 64'(dcyc), 64'd33);
    check("b2b second hi_lo", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk); #1;

    // Reset at count 15 aborts
    launch(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (15) @(posedge clk);
    #1;
    check("pre-reset busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",    {63'd0, busy},    64'd0);
    check("abort alu_own", {63'd0, alu_own}, 64'd0);
    check("abort alu_op",  {61'd0, alu_op},  64'd0);
    check("abort hi_lo",   {hi, lo},         64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("abort no done", 64'(ndone), 64'd0);
    check("abort hi_lo after", {hi, lo}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
